formula_2_result_buffer: RTL and testbench

FORMULA_2_RESULT_BUFFER -- requirements
Module: formula_2_result_buffer

---
 rtl/formula_pkg.sv | 11 +
 rtl/flip_flop_fifo_with_counter.sv | 83 ++++++++
 rtl/formula_2_result_buffer.sv | 99 +++++++++
 tb/tb_formula_2_result_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/formula_pkg.sv
// Shared constants and types for the formula datapath and its result buffer.
package formula_pkg;

  localparam int FORMULA_WIDTH = 32;

  typedef logic [FORMULA_WIDTH-1:0] formula_data_t;

  // Pipeline depth of the integer square-root formula stage feeding the buffer.
  localparam int ISQRT_LATENCY = 16;

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Flip-flop based FIFO with an occupancy counter. Head entry is read
// straight from storage. A push into a full FIFO without a simultaneous pop
// is dropped and flagged on drop_o; the stored contents are left untouched.
module flip_flop_fifo_with_counter
  import formula_pkg::*;
#(
  parameter int WIDTH = FORMULA_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic empty;
  logic full;
  logic pop_ok;
  logic push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = pop_i & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full | pop_ok);

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign drop_o      = push_i & ~push_ok;

  // Next-state for pointers (wrapping at DEPTH-1) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/formula_2_result_buffer.sv
// Credit-managed result buffer behind the formula pipe. Upstream spends one
// credit per issue; a credit comes back when the consumer pops a result, so
// under legal use the FIFO can always absorb every in-flight result.
// Optional protocol checking: FORMULA_2_RESULT_BUFFER_OVERFLOW_CHECK_EN.
module formula_2_result_buffer
  import formula_pkg::*;
#(
  parameter int WIDTH = FORMULA_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_vld,
  output logic                       can_issue,
  input  logic                       res_vld,
  input  logic [WIDTH-1:0]           res,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_CREDITS = CW'(DEPTH);

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;
  logic          pop;

  flip_flop_fifo_with_counter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (res_vld),
    .push_data_i (res),
    .pop_i       (pop),
    .head_data_o (out_data),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  assign out_vld   = (fifo_count != '0);
  assign pop       = out_vld & out_rdy;
  assign can_issue = (credits_q != '0);
  assign credits   = credits_q;

  // Credit update: issue spends, pop returns; saturate at 0 and DEPTH.
  always_comb begin
    credits_d = credits_q;
    case ({issue_vld, pop})
      2'b10: begin
        if (credits_q != '0) credits_d = credits_q - 1'b1;
      end
      2'b01: begin
        if (credits_q != MAX_CREDITS) credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  // Credit register; reset restores the full credit pool immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= MAX_CREDITS;
    end else begin
      credits_q <= credits_d;
    end
  end

`ifdef FORMULA_2_RESULT_BUFFER_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  // Sticky error: dropped result, or an issue with no credit and no pop.
  always_comb begin
    overflow_d = overflow_q | fifo_drop | (issue_vld & ~can_issue & ~pop);
  end

  // Error flag register; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_fifo_drop;

  assign unused_fifo_drop = fifo_drop;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_formula_2_result_buffer.sv
module tb_formula_2_result_buffer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

`ifdef FORMULA_2_RESULT_BUFFER_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_vld;
  logic          can_issue;
  logic          res_vld;
  logic [W-1:0]  res;
  logic          out_vld;
  logic [W-1:0]  out_data;
  logic          out_rdy;
  logic [CW-1:0] credits;
  logic          overflow;

  logic [W-1:0]  sb [$];
  int total = 0;
  int bad   = 0;

  formula_2_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (issue_vld),
    .can_issue (can_issue),
    .res_vld   (res_vld),
    .res       (res),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .credits   (credits),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge, any pop is scored against the queue head.
  task automatic tick();
    logic [W-1:0] exp;
    @(negedge clk);
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk("sb_data", out_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic [W-1:0] d, input bit expect_out);
    res_vld = 1'b1;
    res     = d;
    if (expect_out) sb.push_back(d);
  endtask

  // Spend all credits, then land D results with the consumer stalled.
  task automatic fill(input logic [W-1:0] base);
    out_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      issue_vld = 1'b1;
      tick();
      issue_vld = 1'b0;
    end
    for (int i = 0; i < D; i++) begin
      push_res(base + W'(i), 1'b1);
      tick();
      res_vld = 1'b0;
    end
    chk("fill_credits", 32'(credits), 32'd0);
    chk("fill_vld", 32'(out_vld), 32'd1);
  endtask

  task automatic drain(input string tag);
    out_rdy = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_vld_low"}, 32'(out_vld), 32'd0);
    chk({tag, "_credits"}, 32'(credits), 32'(D));
    out_rdy = 1'b0;
  endtask

  logic [W-1:0] t2_data [4];

  initial begin
    rst = 1'b1; issue_vld = 1'b0; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
    #2;
    chk("rst_credits", 32'(credits), 32'(D));
    chk("rst_can_issue", 32'(can_issue), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Spend all credits with no pops.
    for (int i = 0; i < D; i++) begin
      chk("t1_can_issue_before", 32'(can_issue), 32'd1);
      issue_vld = 1'b1;
      tick();
      issue_vld = 1'b0;
      chk("t1_credits", 32'(credits), 32'(D - 1 - i));
    end
    chk("t1_can_issue_empty", 32'(can_issue), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // Streaming results with the consumer always ready: one-cycle latency.
    t2_data[0] = 32'h11; t2_data[1] = 32'h22; t2_data[2] = 32'h33; t2_data[3] = 32'h44;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_res(t2_data[i], 1'b1);
      tick();
      chk("t2_vld_latency", 32'(out_vld), 32'd1);
      chk("t2_head", out_data, t2_data[i]);
    end
    res_vld = 1'b0;
    drain("t2");

    // Full FIFO held, then simultaneous push/pop/issue at zero credits.
    fill(32'hA1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_data", out_data, 32'hA1);
      chk("t3_hold_vld", 32'(out_vld), 32'd1);
    end
    out_rdy = 1'b1;
    issue_vld = 1'b1;
    push_res(32'h55, 1'b1);
    tick();
    res_vld = 1'b0; issue_vld = 1'b0; out_rdy = 1'b0;
    chk("t3_credits_zero", 32'(credits), 32'd0);
    chk("t3_overflow", 32'(overflow), 32'd0);
    chk("t3_next_head", out_data, 32'hA2);
    drain("t3");

    // Push into a full FIFO without pop: the result is dropped.
    fill(32'hB1);
    push_res(32'h99, 1'b0);
    tick();
    res_vld = 1'b0;
    chk("t4_overflow", 32'(overflow), 32'(OVF_EXP));
    chk("t4_head", out_data, 32'hB1);
    chk("t4_credits", 32'(credits), 32'd0);
    tick();
    chk("t4_overflow_sticky", 32'(overflow), 32'(OVF_EXP));
    drain("t4");

    // Asynchronous reset between edges with results buffered.
    for (int i = 0; i < 2; i++) begin
      issue_vld = 1'b1;
      tick();
      issue_vld = 1'b0;
    end
    push_res(32'hC1, 1'b1); tick();
    push_res(32'hC2, 1'b1); tick();
    res_vld = 1'b0;
    chk("t5_pre_vld", 32'(out_vld), 32'd1);
    chk("t5_pre_credits", 32'(credits), 32'(D - 2));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_vld", 32'(out_vld), 32'd0);
    chk("t5_async_credits", 32'(credits), 32'(D));
    chk("t5_async_can_issue", 32'(can_issue), 32'd1);
    chk("t5_async_overflow", 32'(overflow), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Buffer works normally after reset.
    issue_vld = 1'b1;
    tick();
    issue_vld = 1'b0;
    chk("t6_credits", 32'(credits), 32'(D - 1));
    push_res(32'h77, 1'b1);
    tick();
    res_vld = 1'b0;
    chk("t6_head", out_data, 32'h77);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
